// File: rtl/sprite_compositor_if.sv
// Pixel/collision bundle between the sprite draw engines, the compositor and game logic.
// master: draw-side/consumer driver; slave: the compositor itself.
interface sprite_compositor_if #(
    parameter int N_SPR = 4
);
    localparam int NPAIR = N_SPR * (N_SPR - 1) / 2;

    logic             video_on;
    logic [N_SPR-1:0] spr_draw;
    logic             frame_end;
    logic [7:0]       rgb;
    logic [NPAIR-1:0] coll_flags;
    logic             coll_valid;
    logic             coll_ack;
    logic             coll_overrun;

    modport master (
        output video_on, spr_draw, frame_end, coll_ack,
        input  rgb, coll_flags, coll_valid, coll_overrun
    );

    modport slave (
        input  video_on, spr_draw, frame_end, coll_ack,
        output rgb, coll_flags, coll_valid, coll_overrun
    );
endinterface

// File: rtl/sprite_compositor.sv
// Priority-merges sprite layers into a registered RGB332 pixel and snapshots per-frame layer-pair overlaps.
// Latency: pixel 1 cycle; collision snapshot visible the cycle after frame_end.
// Backpressure: none on pixels; an unacked snapshot is OR-merged with the next one and flags overrun.
module sprite_compositor #(
    parameter int                 N_SPR      = 4,
    parameter logic [8*N_SPR-1:0] SPR_COLORS = {8'hE0, 8'h1C, 8'h03, 8'hFF},
    parameter logic [7:0]         BG_COLOR   = 8'h00
) (
    input logic                clk,
    input logic                rst,
    sprite_compositor_if.slave bus
);
    localparam int NPAIR = N_SPR * (N_SPR - 1) / 2;

    typedef enum logic {IDLE, PENDING} state_t;

    state_t           state, state_nxt;
    logic [7:0]       rgb_q, rgb_nxt;
    logic [NPAIR-1:0] flags_q, flags_nxt;
    logic             ovr_q, ovr_nxt;
    logic [NPAIR-1:0] acc, acc_nxt;
    logic [NPAIR-1:0] hit;
    logic [NPAIR-1:0] snap;

    // Lowest set layer wins, so scan from the top down and let lower indices overwrite.
    always_comb begin
        rgb_nxt = BG_COLOR;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (bus.spr_draw[i]) begin
                rgb_nxt = SPR_COLORS[8*i +: 8];
            end
        end
        if (!bus.video_on) begin
            rgb_nxt = 8'h00;
        end
    end

    // Pair (i,j), i<j, numbered lexicographically.
    for (genvar gi = 0; gi < N_SPR - 1; gi++) begin : g_i
        for (genvar gj = gi + 1; gj < N_SPR; gj++) begin : g_j
            localparam int P = gi * N_SPR - gi * (gi + 1) / 2 + (gj - gi - 1);
            assign hit[P] = bus.video_on & bus.spr_draw[gi] & bus.spr_draw[gj];
        end
    end

    assign snap = acc | hit;

    always_comb begin
        state_nxt = state;
        flags_nxt = flags_q;
        ovr_nxt   = ovr_q;
        acc_nxt   = acc | hit;
        case (state)
            IDLE: begin
                if (bus.frame_end) begin
                    state_nxt = PENDING;
                    flags_nxt = snap;
                    ovr_nxt   = 1'b0;
                    acc_nxt   = '0;
                end
            end
            PENDING: begin
                if (bus.frame_end) begin
                    acc_nxt = '0;
                    if (bus.coll_ack) begin
                        flags_nxt = snap;
                        ovr_nxt   = 1'b0;
                    end else begin
                        flags_nxt = flags_q | snap;
                        ovr_nxt   = 1'b1;
                    end
                end else if (bus.coll_ack) begin
                    state_nxt = IDLE;
                    ovr_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rgb_q   <= '0;
            flags_q <= '0;
            ovr_q   <= 1'b0;
            acc     <= '0;
        end else begin
            state   <= state_nxt;
            rgb_q   <= rgb_nxt;
            flags_q <= flags_nxt;
            ovr_q   <= ovr_nxt;
            acc     <= acc_nxt;
        end
    end

    assign bus.rgb          = rgb_q;
    assign bus.coll_flags   = flags_q;
    assign bus.coll_valid   = (state == PENDING);
    assign bus.coll_overrun = ovr_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed-vector bench for sprite_compositor with N_SPR=4 default colours.
module tb_sprite_compositor;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sprite_compositor_if #(.N_SPR(4)) bus ();

    sprite_compositor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       video_on;
        logic [3:0] spr_draw;
        logic       frame_end;
        logic       coll_ack;
        logic [7:0] exp_rgb;
        logic [5:0] exp_flags;
        logic       exp_valid;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock once, then compare all outputs.
    task automatic apply(input vec_t v, input string tag);
        rst           = v.rst;
        bus.video_on  = v.video_on;
        bus.spr_draw  = v.spr_draw;
        bus.frame_end = v.frame_end;
        bus.coll_ack  = v.coll_ack;
        @(posedge clk);
        #1;
        chk({tag, " rgb"},     {24'h0, bus.rgb},        {24'h0, v.exp_rgb});
        chk({tag, " flags"},   {26'h0, bus.coll_flags}, {26'h0, v.exp_flags});
        chk({tag, " valid"},   {31'h0, bus.coll_valid}, {31'h0, v.exp_valid});
        chk({tag, " overrun"}, {31'h0, bus.coll_overrun}, {31'h0, v.exp_ovr});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.video_on = 1'b0;
        bus.spr_draw = '0;
        bus.frame_end = 1'b0;
        bus.coll_ack = 1'b0;

        //                rst von draw     fe ack  rgb    flags      v  ovr
        // Priority / colours; hit on pair (1,2) lands in acc.
        vecs.push_back('{0, 1, 4'b0110, 0, 0, 8'h03, 6'b000000, 0, 0});
        vecs.push_back('{0, 1, 4'b0000, 0, 0, 8'h00, 6'b000000, 0, 0});
        vecs.push_back('{0, 0, 4'b1000, 0, 0, 8'h00, 6'b000000, 0, 0});
        vecs.push_back('{0, 1, 4'b0001, 0, 0, 8'hFF, 6'b000000, 0, 0});
        vecs.push_back('{0, 1, 4'b1000, 0, 0, 8'hE0, 6'b000000, 0, 0});
        vecs.push_back('{0, 1, 4'b0100, 0, 0, 8'h1C, 6'b000000, 0, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b001000, 1, 0});
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b001000, 0, 0});
        // Collision accumulate; blanked overlap ignored; stray ack ignored.
        vecs.push_back('{0, 1, 4'b0101, 0, 0, 8'hFF, 6'b001000, 0, 0});
        vecs.push_back('{0, 0, 4'b1100, 0, 0, 8'h00, 6'b001000, 0, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b000010, 1, 0});
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b000010, 0, 0});
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b000010, 0, 0});
        // Overrun merge, then ack clears valid and overrun.
        vecs.push_back('{0, 1, 4'b0011, 0, 0, 8'hFF, 6'b000010, 0, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b000001, 1, 0});
        vecs.push_back('{0, 1, 4'b1100, 0, 0, 8'h1C, 6'b000001, 1, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b100001, 1, 1});
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b100001, 0, 0});
        // Ack together with frame_end replaces the snapshot.
        vecs.push_back('{0, 1, 4'b1010, 0, 0, 8'h03, 6'b100001, 0, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b010000, 1, 0});
        vecs.push_back('{0, 1, 4'b0110, 0, 0, 8'h03, 6'b010000, 1, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 1, 8'h00, 6'b001000, 1, 0});
        // Same-cycle hit included; next frame starts empty.
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b001000, 0, 0});
        vecs.push_back('{0, 1, 4'b0011, 1, 0, 8'hFF, 6'b000001, 1, 0});
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b000001, 0, 0});
        vecs.push_back('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b000000, 1, 0});
        vecs.push_back('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b000000, 0, 0});

        apply('{1, 0, 4'b0000, 0, 0, 8'h00, 6'b000000, 0, 0}, "init_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Reset overriding frame_end/ack mid-frame with a pending snapshot and full acc.
        apply('{0, 1, 4'b0110, 1, 0, 8'h03, 6'b001000, 1, 0}, "rs_pend");
        apply('{0, 1, 4'b1111, 0, 0, 8'hFF, 6'b001000, 1, 0}, "rs_fill");
        apply('{1, 1, 4'b1111, 1, 1, 8'h00, 6'b000000, 0, 0}, "rs_reset");
        apply('{0, 0, 4'b0000, 1, 0, 8'h00, 6'b000000, 1, 0}, "rs_empty");

        // Double overrun keeps overrun set and keeps merging.
        apply('{0, 1, 4'b1001, 1, 0, 8'hFF, 6'b000100, 1, 1}, "ov2_a");
        apply('{0, 1, 4'b0011, 1, 0, 8'hFF, 6'b000101, 1, 1}, "ov2_b");
        apply('{0, 0, 4'b0000, 0, 1, 8'h00, 6'b000101, 0, 0}, "ov2_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Downstream stage of the per-sprite draw engines: combines the 1-bit `spr_draw` outputs of up to `N_SPR` sprite engines into one registered RGB332 pixel for the VGA output pins. It also detects pixel-level overlaps between sprite layers during each frame. At every frame boundary it hands a collision snapshot to game logic through a valid/ack handshake. It sits between the draw engines and the VGA pin registers, clocked on the pixel clock.

## Interface
Parameters:
- `N_SPR`, 4: number of sprite layers; legal range 2..8. Layer 0 has the highest priority.
- `SPR_COLORS`, {8'hE0, 8'h1C, 8'h03, 8'hFF}: flattened 8·N_SPR-bit vector. Layer i colour is bits [8i+7:8i], so layer 0 is 8'hFF (white), layer 1 is 8'h03, layer 2 is 8'h1C, layer 3 is 8'hE0.
- `BG_COLOR`, 8'h00: colour inside the visible area when no layer draws.
- `NPAIR`, N_SPR·(N_SPR−1)/2: localparam giving the collision-pair count.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `video_on` in 1: high while the current pixel is in the visible area.
- `spr_draw` in N_SPR: bit i is layer i's draw request for the current pixel.
- `frame_end` in 1: one-cycle pulse at the start of vertical blank.
- `rgb` out 8: registered {R[2:0], G[2:0], B[1:0]}.
- `coll_flags` out NPAIR: collision snapshot for the last completed frame.
- `coll_valid` out 1: snapshot pending.
- `coll_ack` in 1: consumer accepts the snapshot.
- `coll_overrun` out 1: a snapshot was merged before it was acked.

## Operation
- Pair index mapping: pairs (i,j) with i<j are numbered lexicographically. For N_SPR=4 this gives (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- Pixel path, registered every cycle:
  - `video_on`=0: `rgb` ← 0.
  - Otherwise, if any `spr_draw` bit is set: `rgb` ← colour of the lowest-index set bit.
  - Otherwise: `rgb` ← BG_COLOR.
- Hit vector: `hit[p]` = video_on & spr_draw[i] & spr_draw[j] for pair p=(i,j). The internal accumulator `acc` (NPAIR bits) captures it each cycle: `acc` ← `acc` | `hit`.
- Frame boundary. On a `frame_end` cycle, `snap` = `acc` | `hit` (the current cycle's hits are included).
  - Case A, `coll_valid`=0, or `coll_valid`=1 and `coll_ack`=1 in the same cycle:
    - `coll_flags` ← `snap`
    - `coll_valid` ← 1
    - `coll_overrun` ← 0
  - Case B, `coll_valid`=1 and `coll_ack`=0:
    - `coll_flags` ← `coll_flags` | `snap`
    - `coll_overrun` ← 1
    - `coll_valid` stays 1
  - In both cases `acc` ← 0.
- Ack without `frame_end`: if `coll_valid`=1 and `coll_ack`=1, then `coll_valid` ← 0 and `coll_overrun` ← 0. `coll_flags` holds its value.
- Ack while `coll_valid`=0: ignored.
- Handshake state machine:
  - IDLE (`coll_valid`=0) → PENDING on `frame_end`.
  - PENDING → IDLE on `coll_ack` without `frame_end`.
  - PENDING → PENDING on `frame_end`, using Case A or Case B.
- The snapshot is always written even when it is all-zero. A frame with no collisions still raises `coll_valid` with `coll_flags`=0.

## Timing
- Reset: all values below are 0 one cycle after `rst` is sampled high.
  - `rgb`, `coll_flags`, `coll_valid`, `coll_overrun`, `acc`.
  - `rst` overrides every other input, including `frame_end` and `coll_ack` in the same cycle.
  - A reset mid-frame discards the accumulated hits.
- Pixel latency is exactly 1 cycle: inputs sampled at edge n appear on `rgb` after edge n.
- The collision snapshot becomes visible the cycle after `frame_end`.
- `coll_valid` stays high until the edge that samples `coll_ack`=1.
- No combinational path exists from any input to any output.

## Test plan
- Reset: run arbitrary traffic, then pulse `rst` for 1 cycle together with `frame_end` and `coll_ack`. Required: all outputs 0 on the next cycle, and `acc` is empty (next `frame_end` with no draws gives `coll_flags`=0).
- Priority: `video_on`=1 with `spr_draw`=4'b0110, then 4'b0000, then 4'b1000 with `video_on`=0. Required: `rgb` = 8'h03, then 8'h00 (BG_COLOR), then 8'h00 (blanking), each one cycle later.
- Collision accumulate: `spr_draw`=4'b0101 with `video_on`=1 for one cycle; later 4'b1100 with `video_on`=0; then `frame_end`. Required: `coll_flags`=6'b000010, `coll_valid`=1. The blanked overlap is not counted.
- Same-cycle hit: `frame_end` together with `spr_draw`=4'b0011 and `video_on`=1. Required: bit 0 is set in that snapshot, and the following frame's `acc` starts at 0.
- Overrun: frame 1 collides pair 0 and is not acked; frame 2 collides pair 5. Required: `coll_flags`=6'b100001 and `coll_overrun`=1. Then `coll_ack` alone gives `coll_valid`=0 and `coll_overrun`=0 on the next cycle.
- Ack collision: `coll_ack` and `frame_end` in the same cycle while `coll_valid`=1. Required: `coll_flags` is replaced (not OR-merged), `coll_valid` stays 1, and `coll_overrun`=0.
